dsp_data_ram: RTL and testbench

Parametrised multi-bank data RAM for the SCU DSP: BANKS independent banks of 2^ADDR_W words, each addressed by its own auto-incrementing pointer (CT0..CTn), with a DSP read port, a DSP write port and an arbitrated host (CPU bus) port. It sits between the DSP execution unit and the SCU register interface, replacing single-bank RAM instances plus external pointer logic.

---
 rtl/dsp_data_ram.sv | 152 +++++++++++++++
 tb/tb_dsp_data_ram.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_data_ram.sv
// Multi-bank DSP data RAM: per-bank auto-incrementing pointers, DSP read/write ports, arbitrated host port.
// Optional macro DSP_DRAM_FWD_EN: same-bank DSP read+write in one cycle returns the write data (write-through).
module dsp_data_ram #(
    parameter int BANKS  = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter     INIT_FILE = " ",
    localparam int BW    = $clog2(BANKS)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      CE,
    input  logic                      RD_EN,
    input  logic [BW-1:0]             RD_BANK,
    output logic [DATA_W-1:0]         RD_DATA,
    input  logic                      WR_EN,
    input  logic [BW-1:0]             WR_BANK,
    input  logic [DATA_W-1:0]         WR_DATA,
    input  logic [BANKS-1:0]          CT_INC,
    input  logic [BANKS-1:0]          CT_LD,
    input  logic [ADDR_W-1:0]         CT_LD_VAL,
    output logic [BANKS*ADDR_W-1:0]   CT_OUT,
    output logic [BANKS-1:0]          CT_WRAP,
    input  logic                      HOST_REQ,
    input  logic                      HOST_WE,
    input  logic [BW+ADDR_W-1:0]      HOST_ADDR,
    input  logic [DATA_W-1:0]         HOST_WDATA,
    output logic [DATA_W-1:0]         HOST_RDATA,
    output logic                      HOST_ACK,
    output logic                      HOST_BUSY
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, ACK} host_state_t;

    host_state_t state_reg, state_next;
    logic [BW-1:0]     host_bank;
    logic [ADDR_W-1:0] host_word;
    logic              host_blocked;
    logic              host_go;
    logic [DATA_W-1:0] rd_word;

    logic [BANKS-1:0][ADDR_W-1:0] ct_all;
    logic [BANKS-1:0]             wrap_all;
    logic [BANKS-1:0][DATA_W-1:0] dsp_rd_word;
    logic [BANKS-1:0][DATA_W-1:0] host_rd_word;

    // INIT_FILE is consumed by the device flow; no power-up contents are modelled here.
    logic unused_init;
    assign unused_init = ^INIT_FILE;

    assign {host_bank, host_word} = HOST_ADDR;
    assign CT_OUT   = ct_all;
    assign CT_WRAP  = wrap_all;
    assign HOST_ACK = (state_reg == ACK);

    genvar gi;
    generate
        for (gi = 0; gi < BANKS; gi++) begin : g_bank
            logic [DATA_W-1:0] mem [DEPTH];
            logic [ADDR_W-1:0] ct_reg;
            logic              wrap_reg;
            logic              dsp_we;
            logic              host_we;

            assign dsp_we  = WR_EN && (WR_BANK == BW'(gi));
            assign host_we = host_go && HOST_WE && (host_bank == BW'(gi));

            // Arbitration guarantees DSP and host never write the same bank in one cycle.
            always_ff @(posedge CLK) begin
                if (CE) begin
                    if (dsp_we)
                        mem[ct_reg] <= WR_DATA;
                    else if (host_we)
                        mem[host_word] <= HOST_WDATA;
                end
            end

            assign dsp_rd_word[gi]  = mem[ct_reg];
            assign host_rd_word[gi] = mem[host_word];

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    ct_reg   <= '0;
                    wrap_reg <= 1'b0;
                end else if (CE) begin
                    if (CT_LD[gi]) begin
                        ct_reg   <= CT_LD_VAL;
                        wrap_reg <= 1'b0;
                    end else if (CT_INC[gi]) begin
                        ct_reg   <= ct_reg + 1'b1;
                        wrap_reg <= &ct_reg;
                    end else begin
                        wrap_reg <= 1'b0;
                    end
                end
            end

            assign ct_all[gi]   = ct_reg;
            assign wrap_all[gi] = wrap_reg;
        end
    endgenerate

    always_comb begin
`ifdef DSP_DRAM_FWD_EN
        // Same bank implies same pointer, so a bank match is a full address match.
        rd_word = (WR_EN && (WR_BANK == RD_BANK)) ? WR_DATA : dsp_rd_word[RD_BANK];
`else
        rd_word = dsp_rd_word[RD_BANK];
`endif
    end

    always_comb begin
        host_blocked = (RD_EN && (RD_BANK == host_bank)) || (WR_EN && (WR_BANK == host_bank));
        state_next   = state_reg;
        host_go      = 1'b0;
        HOST_BUSY    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (HOST_REQ) begin
                    if (host_blocked) begin
                        HOST_BUSY = 1'b1;
                    end else begin
                        host_go    = !RST;
                        state_next = ACK;
                    end
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state_reg <= IDLE;
        else if (CE)
            state_reg <= state_next;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RD_DATA    <= '0;
            HOST_RDATA <= '0;
        end else if (CE) begin
            if (RD_EN)
                RD_DATA <= rd_word;
            if (host_go && !HOST_WE)
                HOST_RDATA <= host_rd_word[host_bank];
        end
    end
endmodule

// File: tb/tb_dsp_data_ram.sv
// Bench for dsp_data_ram: word-level memory/pointer/host model checked every cycle, plus literal expectations.
module tb_dsp_data_ram;
    localparam int NB = 4;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int BB = 2;
    localparam int DEPTH = 1 << AW;
`ifdef DSP_DRAM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic CLK, RST, CE;
    logic RD_EN, WR_EN, HOST_REQ, HOST_WE, HOST_ACK, HOST_BUSY;
    logic [BB-1:0] RD_BANK, WR_BANK;
    logic [DW-1:0] RD_DATA, WR_DATA, HOST_WDATA, HOST_RDATA;
    logic [NB-1:0] CT_INC, CT_LD, CT_WRAP;
    logic [AW-1:0] CT_LD_VAL;
    logic [NB*AW-1:0] CT_OUT;
    logic [BB+AW-1:0] HOST_ADDR;

    int errors = 0;
    int checks = 0;

    dsp_data_ram #(.BANKS(NB), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RST(RST), .CE(CE),
        .RD_EN(RD_EN), .RD_BANK(RD_BANK), .RD_DATA(RD_DATA),
        .WR_EN(WR_EN), .WR_BANK(WR_BANK), .WR_DATA(WR_DATA),
        .CT_INC(CT_INC), .CT_LD(CT_LD), .CT_LD_VAL(CT_LD_VAL),
        .CT_OUT(CT_OUT), .CT_WRAP(CT_WRAP),
        .HOST_REQ(HOST_REQ), .HOST_WE(HOST_WE), .HOST_ADDR(HOST_ADDR),
        .HOST_WDATA(HOST_WDATA), .HOST_RDATA(HOST_RDATA),
        .HOST_ACK(HOST_ACK), .HOST_BUSY(HOST_BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model state: memory contents, which words are defined, pointers, and the host handshake.
    logic [DW-1:0] m_mem [NB][DEPTH];
    bit            m_known [NB][DEPTH];
    int            m_ct [NB];
    bit            m_wrap [NB];
    bit            m_ack;
    logic [DW-1:0] m_rd, m_hr;
    bit            m_rd_ok, m_hr_ok;

    function automatic bit touched(input int bank);
        return (RD_EN && int'(RD_BANK) == bank) || (WR_EN && int'(WR_BANK) == bank);
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int b = 0; b < NB; b++) begin
                m_ct[b]   <= 0;
                m_wrap[b] <= 1'b0;
            end
            m_ack   <= 1'b0;
            m_rd    <= '0;
            m_rd_ok <= 1'b1;
            m_hr    <= '0;
            m_hr_ok <= 1'b1;
        end else if (CE) begin
            if (RD_EN) begin
                if (FWD && WR_EN && WR_BANK == RD_BANK) begin
                    m_rd    <= WR_DATA;
                    m_rd_ok <= 1'b1;
                end else begin
                    m_rd    <= m_mem[RD_BANK][m_ct[RD_BANK]];
                    m_rd_ok <= m_known[RD_BANK][m_ct[RD_BANK]];
                end
            end
            if (m_ack) begin
                m_ack <= 1'b0;
            end else if (HOST_REQ && !touched(int'(HOST_ADDR[AW +: BB]))) begin
                m_ack <= 1'b1;
                if (HOST_WE) begin
                    m_mem[HOST_ADDR[AW +: BB]][HOST_ADDR[AW-1:0]]   <= HOST_WDATA;
                    m_known[HOST_ADDR[AW +: BB]][HOST_ADDR[AW-1:0]] <= 1'b1;
                end else begin
                    m_hr    <= m_mem[HOST_ADDR[AW +: BB]][HOST_ADDR[AW-1:0]];
                    m_hr_ok <= m_known[HOST_ADDR[AW +: BB]][HOST_ADDR[AW-1:0]];
                end
            end
            if (WR_EN) begin
                m_mem[WR_BANK][m_ct[WR_BANK]]   <= WR_DATA;
                m_known[WR_BANK][m_ct[WR_BANK]] <= 1'b1;
            end
            for (int b = 0; b < NB; b++) begin
                if (CT_LD[b]) begin
                    m_ct[b]   <= int'(CT_LD_VAL);
                    m_wrap[b] <= 1'b0;
                end else if (CT_INC[b]) begin
                    m_ct[b]   <= (m_ct[b] + 1) % DEPTH;
                    m_wrap[b] <= (m_ct[b] == DEPTH - 1);
                end else begin
                    m_wrap[b] <= 1'b0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        logic [NB*AW-1:0] e_ct;
        logic [NB-1:0]    e_wrap;
        if (!RST) begin
            for (int b = 0; b < NB; b++) begin
                e_ct[b*AW +: AW] = AW'(m_ct[b]);
                e_wrap[b]        = m_wrap[b];
            end
            if (m_rd_ok) chk("rd_data", RD_DATA, m_rd);
            if (m_hr_ok) chk("host_rdata", HOST_RDATA, m_hr);
            chk("host_ack", HOST_ACK, m_ack);
            chk("host_busy", HOST_BUSY, !m_ack && HOST_REQ && touched(int'(HOST_ADDR[AW +: BB])));
            chk("ct_out", CT_OUT, e_ct);
            chk("ct_wrap", CT_WRAP, e_wrap);
        end
    end

    task automatic clr();
        RD_EN = 0; RD_BANK = '0; WR_EN = 0; WR_BANK = '0; WR_DATA = '0;
        CT_INC = '0; CT_LD = '0; CT_LD_VAL = '0;
        HOST_REQ = 0; HOST_WE = 0; HOST_ADDR = '0; HOST_WDATA = '0;
    endtask

    // One clock: inputs set before the call are sampled, then cleared; returns 3 time units after the edge.
    task automatic step();
        @(posedge CLK);
        #2;
        clr();
        #1;
    endtask

    task automatic host(input bit we, input int bank, input int word, input logic [DW-1:0] data);
        HOST_REQ = 1; HOST_WE = we;
        HOST_ADDR = {BB'(bank), AW'(word)};
        HOST_WDATA = data;
    endtask

    initial begin
        RST = 1; CE = 1;
        clr();
        step(); step();
        RST = 0;
        #1;
        chk("rst_ct_out", CT_OUT, 0);
        chk("rst_rd_data", RD_DATA, 0);
        chk("rst_host_rdata", HOST_RDATA, 0);
        chk("rst_host_ack", HOST_ACK, 0);
        chk("rst_host_busy", HOST_BUSY, 0);
        chk("rst_ct_wrap", CT_WRAP, 0);

        CT_LD = 4'b0001; CT_LD_VAL = 5; step();
        chk("ct0_load", CT_OUT[AW-1:0], 5);
        WR_EN = 1; WR_BANK = 0; WR_DATA = 32'hDEADBEEF; CT_INC = 4'b0001; step();
        chk("ct0_after_write", CT_OUT[AW-1:0], 6);
        CT_LD = 4'b0001; CT_LD_VAL = 5; step();
        RD_EN = 1; RD_BANK = 0; step();
        chk("rd_deadbeef", RD_DATA, 32'hDEADBEEF);

        CT_LD = 4'b0010; CT_LD_VAL = 63; step();
        CT_INC = 4'b0010; step();
        chk("ct1_wrapped", CT_OUT[AW +: AW], 0);
        chk("wrap_pulse", CT_WRAP, 4'b0010);
        step();
        chk("wrap_single", CT_WRAP, 4'b0000);
        CT_LD = 4'b0010; CT_LD_VAL = 63; step();
        CT_LD = 4'b0010; CT_INC = 4'b0010; CT_LD_VAL = 10; step();
        chk("ld_beats_inc", CT_OUT[AW +: AW], 10);
        chk("ld_no_wrap", CT_WRAP, 4'b0000);

        host(1, 2, 7, 32'h12345678); step();
        chk("hw_ack", HOST_ACK, 1);
        step();
        chk("hw_ack_drop", HOST_ACK, 0);
        host(0, 2, 7, '0); step();
        chk("hr_ack", HOST_ACK, 1);
        chk("hr_data", HOST_RDATA, 32'h12345678);
        step();

        host(1, 3, 0, 32'hA5A50003); step(); step();
        for (int k = 0; k < 4; k++) begin
            host(0, 3, 0, '0); RD_EN = 1; RD_BANK = 3;
            #1 chk("busy_blocked", HOST_BUSY, 1);
            step();
        end
        host(0, 3, 0, '0);
        #1 chk("busy_released", HOST_BUSY, 0);
        step();
        chk("stall_ack", HOST_ACK, 1);
        chk("stall_hr_data", HOST_RDATA, 32'hA5A50003);
        chk("stall_dsp_rd", RD_DATA, 32'hA5A50003);
        step();
        host(1, 0, 20, 32'h0BADF00D); RD_EN = 1; RD_BANK = 3;
        #1 chk("other_bank_no_busy", HOST_BUSY, 0);
        step();
        chk("other_bank_ack", HOST_ACK, 1);
        step();

        CT_LD = 4'b0001; CT_LD_VAL = 9; host(1, 0, 9, 32'h1); step(); step();
        RD_EN = 1; RD_BANK = 0; WR_EN = 1; WR_BANK = 0; WR_DATA = 32'h2; step();
        chk("rw_same_bank", RD_DATA, FWD ? 32'h2 : 32'h1);
        RD_EN = 1; RD_BANK = 0; step();
        chk("rw_followup", RD_DATA, 32'h2);

        host(1, 1, 33, 32'hCAFE0001); step();
        chk("pre_rst_ack", HOST_ACK, 1);
        RST = 1;
        #1;
        chk("rst_kills_ack", HOST_ACK, 0);
        chk("rst_clears_ct", CT_OUT, 0);
        step();
        RST = 0;
        #1 chk("rst_rd_zero", RD_DATA, 0);
        CT_LD = 4'b0010; CT_LD_VAL = 33; step();
        RD_EN = 1; RD_BANK = 1; step();
        chk("write_survives_rst", RD_DATA, 32'hCAFE0001);

        host(1, 2, 1, 32'h77); step();
        chk("ce_ack_on", HOST_ACK, 1);
        CE = 0; CT_INC = '1; step();
        chk("ce_ack_held", HOST_ACK, 1);
        chk("ce_ct_frozen", CT_OUT[AW +: AW], 33);
        CT_INC = '1; step();
        chk("ce_ack_held2", HOST_ACK, 1);
        CE = 1; step();
        chk("ce_ack_done", HOST_ACK, 0);

        CT_LD = '1; CT_LD_VAL = 0; step();
        for (int i = 0; i < 16; i++) begin
            WR_EN = 1; WR_BANK = BB'(i % NB); WR_DATA = i * 32'h01010101 + 32'h1;
            CT_INC = NB'(1 << (i % NB));
            RD_EN = 1; RD_BANK = BB'((i + 1) % NB);
            step();
        end
        CT_LD = '1; CT_LD_VAL = 0; step();
        for (int i = 0; i < 16; i++) begin
            RD_EN = 1; RD_BANK = BB'(i % NB); CT_INC = NB'(1 << (i % NB));
            host(0, (i + 2) % NB, i / NB, '0);
            step();
        end
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
